fpga_computer: RTL and testbench



---
 rtl/fpga_computer_pkg.sv | 32 +++
 rtl/fpga_computer_alu8.sv | 29 ++
 rtl/fpga_computer.sv | 108 ++++++++++
 tb/tb_fpga_computer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_computer_pkg.sv
// Shared constants for the front-panel teaching computer: module select codes
// and ALU operation codes.
package fpga_computer_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  // Module select codes driven on SEL; codes 8-15 select nothing.
  typedef enum logic [3:0] {
    SEL_PC   = 4'd0,
    SEL_ACC  = 4'd1,
    SEL_BREG = 4'd2,
    SEL_ALU  = 4'd3,
    SEL_MAR  = 4'd4,
    SEL_RAM  = 4'd5,
    SEL_OUT  = 4'd6,
    SEL_IR   = 4'd7
  } sel_e;

  // ALU operation codes driven on OP.
  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    DEC = 3'd2,
    INC = 3'd3,
    OC  = 3'd4,
    BND = 3'd5,
    BOR = 3'd6,
    BXR = 3'd7
  } alu_op_e;

endpackage

// File: rtl/fpga_computer_alu8.sv
// Combinational 8-bit ALU: A is the accumulator, B the B register.
// All results wrap modulo 256; there are no flag outputs.
module fpga_computer_alu8
  import fpga_computer_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] result
);

  // Select the operation result for the current opcode.
  always_comb begin
    // NOTE: default assignment first so every path drives result and no latch is inferred.
    result = '0;
    case (op)
      ADD:     result = a + b;
      SUB:     result = a - b;
      DEC:     result = a - 8'd1;
      INC:     result = a + 8'd1;
      OC:      result = ~a;
      BND:     result = a & b;
      BOR:     result = a | b;
      BXR:     result = a ^ b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/fpga_computer.sv
// Top level of the front-panel teaching computer. One module is selected at a
// time; PRGM loads it from the switches, WE loads it from the bus register and
// OE copies its contents into the bus register. The PC free-runs while ON.
module fpga_computer
  import fpga_computer_pkg::*;
#(
  parameter int RAM_DEPTH = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] SEL,
  input  logic [7:0] PRGM_IN,
  input  logic [2:0] OP,
  input  logic       EN,
  input  logic       GO,
  input  logic       OE,
  input  logic       WE,
  input  logic       PRGM,
  input  logic       HLT,
  output logic [3:0] COUNT,
  output logic [7:0] BUS_OUT,
  output logic [7:0] CURRENT,
  output logic       ON
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] breg;
  logic [DATA_W-1:0] out_q;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] bus_q;
  logic              on_q;
  logic [DATA_W-1:0] ram [RAM_DEPTH];

  logic [DATA_W-1:0] alu_y;
  logic [DATA_W-1:0] current_val;
  logic              load_en;
  logic [DATA_W-1:0] load_data;

  fpga_computer_alu8 u_alu (
    .a      (acc),
    .b      (breg),
    .op     (OP),
    .result (alu_y)
  );

  // Manual load source: switches win over the bus register.
  assign load_en   = PRGM | WE;
  assign load_data = PRGM ? PRGM_IN : bus_q;

  // Contents of the selected module, shown on the panel and offered to the bus.
  always_comb begin
    current_val = '0;
    case (SEL)
      SEL_PC:   current_val = {4'b0, pc};
      SEL_ACC:  current_val = acc;
      SEL_BREG: current_val = breg;
      SEL_ALU:  current_val = alu_y;
      SEL_MAR:  current_val = {4'b0, mar};
      SEL_RAM:  current_val = ram[mar];
      SEL_OUT:  current_val = out_q;
      SEL_IR:   current_val = ir;
      default:  current_val = '0;
    endcase
  end

  // Register file, bus register, run flag and RAM; manual loads, bus capture and PC stepping.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      // NOTE: RAM is deliberately left out of the reset branch; its contents survive reset.
      pc    <= '0;
      mar   <= '0;
      acc   <= '0;
      breg  <= '0;
      out_q <= '0;
      ir    <= '0;
      bus_q <= '0;
      on_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so OE samples the pre-edge value of a module loaded on the same edge.
      on_q <= GO & EN & ~HLT;

      if (OE) bus_q <= current_val;

      if (load_en && SEL == SEL_PC) pc <= load_data[3:0];
      else if (on_q && !HLT)        pc <= pc + 4'd1;

      if (load_en) begin
        case (SEL)
          SEL_ACC:  acc       <= load_data;
          SEL_BREG: breg      <= load_data;
          SEL_MAR:  mar       <= load_data[3:0];
          SEL_RAM:  ram[mar]  <= load_data;
          SEL_OUT:  out_q     <= load_data;
          SEL_IR:   ir        <= load_data;
          default:  ;
        endcase
      end
    end
  end

  assign COUNT   = pc;
  assign BUS_OUT = bus_q;
  assign CURRENT = current_val;
  assign ON      = on_q;

endmodule

// File: tb/tb_fpga_computer.sv
// Self-checking bench for fpga_computer: expectations are queued as stimulus is
// applied and drained against the DUT outputs once they should have settled.
module tb_fpga_computer;
  import fpga_computer_pkg::*;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] SEL;
  logic [7:0] PRGM_IN;
  logic [2:0] OP;
  logic       EN, GO, OE, WE, PRGM, HLT;
  logic [3:0] COUNT;
  logic [7:0] BUS_OUT;
  logic [7:0] CURRENT;
  logic       ON;

  fpga_computer #(.RAM_DEPTH(16)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .SEL     (SEL),
    .PRGM_IN (PRGM_IN),
    .OP      (OP),
    .EN      (EN),
    .GO      (GO),
    .OE      (OE),
    .WE      (WE),
    .PRGM    (PRGM),
    .HLT     (HLT),
    .COUNT   (COUNT),
    .BUS_OUT (BUS_OUT),
    .CURRENT (CURRENT),
    .ON      (ON)
  );

  always #5 CLK = ~CLK;

  typedef enum {K_CUR, K_BUS, K_CNT, K_ON} kind_e;
  typedef struct {
    string      tag;
    kind_e      kind;
    logic [7:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
  endtask

  task automatic expect_out(input string tag, input kind_e kind, input logic [7:0] exp);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.exp  = exp;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    while (exp_q.size() > 0) begin
      exp_t       e;
      logic [7:0] obs;
      e = exp_q.pop_front();
      case (e.kind)
        K_CUR:   obs = CURRENT;
        K_BUS:   obs = BUS_OUT;
        K_CNT:   obs = {4'b0, COUNT};
        default: obs = {7'b0, ON};
      endcase
      check(e.tag, obs, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic prgm(input logic [3:0] s, input logic [7:0] d);
    SEL = s; PRGM_IN = d; PRGM = 1'b1;
    tick();
    PRGM = 1'b0;
  endtask

  task automatic we(input logic [3:0] s);
    SEL = s; WE = 1'b1;
    tick();
    WE = 1'b0;
  endtask

  task automatic oe(input logic [3:0] s);
    SEL = s; OE = 1'b1;
    tick();
    OE = 1'b0;
  endtask

  // Expected ALU results for ACC=0xAA, BREG=0x55, OP 0..7.
  logic [7:0] alu_tbl [8] = '{8'hFF, 8'h55, 8'hA9, 8'hAB, 8'h55, 8'h00, 8'hFF, 8'hFF};

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_pc;

    RESET = 1'b1; SEL = SEL_ACC; PRGM_IN = 8'h77; OP = ADD;
    EN = 1'b0; GO = 1'b0; OE = 1'b0; WE = 1'b0; PRGM = 1'b1; HLT = 1'b0;
    tick();
    tick();
    PRGM = 1'b0;
    expect_out("rst_acc", K_CUR, 8'h00);
    expect_out("rst_bus", K_BUS, 8'h00);
    expect_out("rst_cnt", K_CNT, 8'h00);
    expect_out("rst_on",  K_ON,  8'h00);
    drain();

    RESET = 1'b0;
    tick();

    prgm(SEL_ACC, 8'hAA);
    expect_out("load_acc", K_CUR, 8'hAA);
    drain();
    prgm(SEL_BREG, 8'h55);
    expect_out("load_breg", K_CUR, 8'h55);
    expect_out("load_cnt",  K_CNT, 8'h00);
    expect_out("load_bus",  K_BUS, 8'h00);
    drain();

    // ALU output is combinational: no clock edge between OP and the sample.
    SEL = SEL_ALU;
    for (int i = 0; i < 8; i++) begin
      OP = 3'(i);
      #1;
      expect_out($sformatf("alu_op%0d", i), K_CUR, alu_tbl[i]);
      drain();
    end

    OP = ADD;
    prgm(SEL_ALU, 8'h12);
    expect_out("alu_readonly", K_CUR, 8'hFF);
    drain();

    oe(SEL_ALU);
    expect_out("oe_alu", K_BUS, 8'hFF);
    drain();
    we(SEL_OUT);
    expect_out("we_out", K_CUR, 8'hFF);
    drain();
    prgm(SEL_IR, 8'h5A);
    expect_out("load_ir", K_CUR, 8'h5A);
    drain();

    oe(4'd9);
    expect_out("oe_unused_bus", K_BUS, 8'h00);
    expect_out("unused_cur",    K_CUR, 8'h00);
    drain();

    // OE and WE together: the bus takes the old ACC, ACC takes the old bus.
    SEL = SEL_ACC; OE = 1'b1; WE = 1'b1;
    tick();
    OE = 1'b0; WE = 1'b0;
    expect_out("oe_we_bus", K_BUS, 8'hAA);
    expect_out("oe_we_acc", K_CUR, 8'h00);
    drain();

    SEL = SEL_BREG; PRGM_IN = 8'h33; PRGM = 1'b1; WE = 1'b1;
    tick();
    PRGM = 1'b0; WE = 1'b0;
    expect_out("prgm_over_we", K_CUR, 8'h33);
    drain();

    prgm(SEL_MAR, 8'h08);
    expect_out("mar_8", K_CUR, 8'h08);
    drain();
    prgm(SEL_RAM, 8'hC3);
    expect_out("ram_8_wr", K_CUR, 8'hC3);
    drain();
    prgm(SEL_MAR, 8'hF7);
    expect_out("mar_trunc", K_CUR, 8'h07);
    drain();
    prgm(SEL_RAM, 8'h3C);
    expect_out("ram_7_wr", K_CUR, 8'h3C);
    drain();
    prgm(SEL_MAR, 8'h08);
    SEL = SEL_RAM;
    #1;
    expect_out("ram_8_rd", K_CUR, 8'hC3);
    drain();

    prgm(SEL_PC, 8'hFD);
    expect_out("pc_load_cnt", K_CNT, 8'h0D);
    expect_out("pc_load_cur", K_CUR, 8'h0D);
    drain();

    GO = 1'b1; EN = 1'b1;
    tick();
    exp_pc = 4'hD;
    expect_out("run_on",    K_ON,  8'h01);
    expect_out("run_first", K_CNT, {4'b0, exp_pc});
    drain();
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_pc = exp_pc + 4'd1;
      expect_out($sformatf("run_step%0d", i), K_CNT, {4'b0, exp_pc});
      drain();
    end

    // Bus still holds 0xAA: a manual load wins over the increment.
    we(SEL_PC);
    expect_out("pc_override", K_CNT, 8'h0A);
    drain();
    tick();
    expect_out("run_after_ovr", K_CNT, 8'h0B);
    drain();

    HLT = 1'b1;
    tick();
    expect_out("hlt_on",  K_ON,  8'h00);
    expect_out("hlt_cnt", K_CNT, 8'h0B);
    drain();
    tick();
    expect_out("hlt_hold", K_CNT, 8'h0B);
    drain();

    HLT = 1'b0;
    tick();
    expect_out("resume_on",  K_ON,  8'h01);
    expect_out("resume_cnt", K_CNT, 8'h0B);
    drain();
    tick();
    expect_out("resume_step", K_CNT, 8'h0C);
    drain();

    // Assert reset between edges; outputs must clear without waiting for a clock.
    #2;
    RESET = 1'b1;
    #1;
    expect_out("async_cnt", K_CNT, 8'h00);
    expect_out("async_bus", K_BUS, 8'h00);
    expect_out("async_on",  K_ON,  8'h00);
    drain();
    tick();
    RESET = 1'b0; GO = 1'b0; EN = 1'b0;

    prgm(SEL_MAR, 8'h07);
    SEL = SEL_RAM;
    #1;
    expect_out("ram_keep_7", K_CUR, 8'h3C);
    drain();
    prgm(SEL_MAR, 8'h08);
    SEL = SEL_RAM;
    #1;
    expect_out("ram_keep_8", K_CUR, 8'hC3);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
